hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the datapath and driving every stage's stall/flush and forwarding mux selects. It supersedes the combinational forwarding/div-stall unit. It adds:
- load-use and branch-operand interlocks;
- decode-stage branch forwarding;
- a counted data-SRAM wait state machine;
- precise exception flush;
- a saturating stall-cycle counter.

## Interface
Parameters:
- REG_W, 5, register-address width
- MEM_LAT, 2, extra wait cycles per data-SRAM access in M (0 = single-cycle memory)
- CNT_W, 32, width of stall_cycles counter

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rsD, rtD  in  REG_W  decode source registers
- branchD  in  1  decode holds branch/jr needing register compare
- rsE, rtE  in  REG_W  execute source registers
- writeregE  in  REG_W  execute destination
- regwriteE, memtoregE  in  1  execute writes reg / is load
- stall_divE  in  1  divider busy in E
- writeregM  in  REG_W; regwriteM, memtoregM, hilo_writeM  in  1 each
- memaccM  in  1  M issues data-SRAM load/store
- exceptM  in  1  exception committed in M this cycle
- writeregW  in  REG_W; regwriteW, hilo_writeW  in  1 each
- forwardaE, forwardbE, forwardHiLoE  out  2  00 regfile/hilo, 10 from M, 01 from W
- forwardaD, forwardbD  out  1  branch operand from M ALU result
- stallF, stallD, stallE, stallM  out  1
- flushD, flushE, flushM, flushW  out  1
- stall_cycles  out  CNT_W  count of cycles with stallF high

## Operation
- Forwarding (combinational): register 0 is never forwarded. M has priority over W. Each select is 00 unless a match is found. forwardHiLoE is 10 if hilo_writeM, else 01 if hilo_writeW, else 00. No select holds state.
- forwardaD = rsD!=0 & rsD==writeregM & regwriteM; forwardbD likewise on rtD.
- lwstall = memtoregE & ((rtE==rsD & rsD!=0) | (rtE==rtD & rtD!=0)).
- brstall = branchD & one of:
  - (regwriteE & writeregE!=0 & writeregE∈{rsD,rtD});
  - (memtoregM & writeregM!=0 & writeregM∈{rsD,rtD}).
- Memory-wait FSM, states IDLE/WAIT, counter wcnt (width ≥ clog2(MEM_LAT+1)):
  - IDLE & memaccM & MEM_LAT>0: memwait=1 this cycle; next WAIT, wcnt=MEM_LAT-1.
  - WAIT & wcnt!=0: memwait=1, wcnt-1.
  - WAIT & wcnt==0: memwait=0 (release cycle), next IDLE. memaccM still high in this cycle must not retrigger.
  - MEM_LAT=0: FSM never leaves IDLE and memwait is always 0.
- Stall/flush equations (exceptM=0):
  - stallM = memwait.
  - stallE = memwait | stall_divE.
  - stallD = stallF = stallE | lwstall | brstall.
  - flushW = memwait.
  - flushM = stall_divE & ~memwait.
  - flushE = (lwstall | brstall) & ~stallE.
  - flushD = 0.
- Exception priority: exceptM=1 overrides everything in that cycle.
  - All stalls are 0 and flushD/E/M/W are 1.
  - FSM is forced to IDLE and wcnt to 0, aborting any wait.
- stall_cycles increments each cycle stallF=1 and saturates at all-ones.

## Timing
- Reset (async, immediate): state IDLE, wcnt 0, stall_cycles 0. All combinational outputs follow from inputs. With inputs quiescent, every stall/flush and select is 0.
- Forwarding, stall and flush outputs are combinational from the current-cycle inputs plus the FSM state. The datapath samples them at the next rising edge.
- A memory access occupies M for MEM_LAT+1 cycles. Stalls are asserted for exactly MEM_LAT consecutive cycles starting the cycle memaccM first rises.
- Back-to-back accesses: a new instruction entering M in the cycle after release re-enters WAIT normally. There is no dead cycle.
- stall_divE concurrent with WAIT: memwait dominates (flushM=0). The divider stall resumes flushing M after release.
- Reset asserted mid-WAIT aborts the access. There is no pending stall after release.

## Test plan
- rsE=rtE=3, writeregM=3 regwriteM=1, writeregW=3 regwriteW=1 -> forwardaE=forwardbE=10. With regwriteM=0 -> 01. With rsE=0 -> forwardaE=00.
- memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1, stallE=0. Next cycle with memtoregE=0 -> all 0. stall_cycles has advanced by 1.
- MEM_LAT=2, memaccM held 3 cycles -> stallF/D/E/M and flushW high for cycles 0-1 and low in cycle 2. A second access starting in cycle 3 repeats the pattern.
- exceptM=1 in WAIT (wcnt=1) -> all stalls 0, flushD/E/M/W=1. Next cycle state IDLE. memaccM for the new instruction waits the full MEM_LAT.
- stall_divE=1 for 4 cycles, no memory access -> stallF/D/E=1 and flushM=1 for 4 cycles, stall_cycles +4. With CNT_W=2 preloaded to 3, the counter stays at 3.
- hilo_writeM=hilo_writeW=0 after a prior hilo_writeM=1 -> forwardHiLoE=00 (no retained value).

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Drives forwarding selects, per-stage stall/flush, a data-SRAM wait
// state machine and a saturating count of front-end stall cycles.
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic             branchD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic             stall_divE,
  input  logic [REG_W-1:0] writeregM,
  input  logic             regwriteM,
  input  logic             memtoregM,
  input  logic             hilo_writeM,
  input  logic             memaccM,
  input  logic             exceptM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteW,
  input  logic             hilo_writeW,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic [1:0]       forwardHiLoE,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = (MEM_LAT > 0) ? WCNT_W'(MEM_LAT - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              memwait;
  logic              lwstall;
  logic              brstall;
  logic              stall_exe;

  // Select for one E operand: M result wins over W, register 0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] wm, input logic rwm,
                                         input logic [REG_W-1:0] ww, input logic rww);
    if (src != '0 && src == wm && rwm)      return 2'b10;
    else if (src != '0 && src == ww && rww) return 2'b01;
    else                                    return 2'b00;
  endfunction

  // Combinational forwarding selects for E and for the decode branch compare.
  always_comb begin
    forwardaE    = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardbE    = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    forwardHiLoE = hilo_writeM ? 2'b10 : (hilo_writeW ? 2'b01 : 2'b00);
    forwardaD    = (rsD != '0) && (rsD == writeregM) && regwriteM;
    forwardbD    = (rtD != '0) && (rtD == writeregM) && regwriteM;
  end

  // Load-use and branch-operand interlock detection.
  always_comb begin
    lwstall = memtoregE && (((rtE == rsD) && (rsD != '0)) || ((rtE == rtD) && (rtD != '0)));
    brstall = branchD && (
                (regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
                (memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));
  end

  // Memory wait is asserted from the first cycle of an access, not one cycle later.
  always_comb begin
    memwait = 1'b0;
    if (MEM_LAT > 0) begin
      if (state == IDLE) memwait = memaccM;
      else               memwait = (wcnt != '0);
    end
  end

  // Wait FSM: counts the extra SRAM cycles; the release cycle drops back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else if (exceptM) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((MEM_LAT > 0) && memaccM) begin
            state <= WAIT;
            wcnt  <= WCNT_INIT;
          end
        end
        WAIT: begin
          if (wcnt != '0) wcnt  <= wcnt - WCNT_W'(1);
          else            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall/flush equations; a committed exception overrides all of them.
  always_comb begin
    stall_exe = memwait || stall_divE;
    if (exceptM) begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      stallM = memwait;
      stallE = stall_exe;
      stallD = stall_exe || lwstall || brstall;
      stallF = stall_exe || lwstall || brstall;
      flushW = memwait;
      flushM = stall_divE && !memwait;
      flushE = (lwstall || brstall) && !stall_exe;
      flushD = 1'b0;
    end
  end

  // Saturating count of cycles in which fetch is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    stall_cycles <= '0;
    else if (stallF && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized bench for hazard_ctrl with a
// behavioural reference model. Two instances share the inputs: one with
// MEM_LAT=2/CNT_W=32 and one with MEM_LAT=0/CNT_W=2.
module tb_hazard_ctrl;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, regwriteE, memtoregE, stall_divE;
  logic       regwriteM, memtoregM, hilo_writeM, memaccM, exceptM;
  logic       regwriteW, hilo_writeW;

  logic [1:0] faE_a, fbE_a, fhE_a, faE_b, fbE_b, fhE_b;
  logic       faD_a, fbD_a, faD_b, fbD_b;
  logic       sF_a, sD_a, sE_a, sM_a, fD_a, fE_a, fM_a, fW_a;
  logic       sF_b, sD_b, sE_b, sM_b, fD_b, fE_b, fM_b, fW_b;
  logic [31:0] cnt_dut_a;
  logic [1:0]  cnt_dut_b;

  int errors = 0;
  int checks = 0;
  bit run = 1'b1;

  // model state: index of the current cycle inside an access (-1 = none)
  int     idx_a = -1, idx_b = -1;
  longint cnt_a = 0, cnt_b = 0;
  int     ci_a, ci_b;
  logic [15:0] exp_a, exp_b, act_a, act_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .MEM_LAT(LAT_A), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .stall_divE(stall_divE), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .hilo_writeM(hilo_writeM),
    .memaccM(memaccM), .exceptM(exceptM), .writeregW(writeregW),
    .regwriteW(regwriteW), .hilo_writeW(hilo_writeW),
    .forwardaE(faE_a), .forwardbE(fbE_a), .forwardHiLoE(fhE_a),
    .forwardaD(faD_a), .forwardbD(fbD_a), .stallF(sF_a), .stallD(sD_a),
    .stallE(sE_a), .stallM(sM_a), .flushD(fD_a), .flushE(fE_a),
    .flushM(fM_a), .flushW(fW_a), .stall_cycles(cnt_dut_a));

  hazard_ctrl #(.REG_W(5), .MEM_LAT(LAT_B), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .stall_divE(stall_divE), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .hilo_writeM(hilo_writeM),
    .memaccM(memaccM), .exceptM(exceptM), .writeregW(writeregW),
    .regwriteW(regwriteW), .hilo_writeW(hilo_writeW),
    .forwardaE(faE_b), .forwardbE(fbE_b), .forwardHiLoE(fhE_b),
    .forwardaD(faD_b), .forwardbD(fbD_b), .stallF(sF_b), .stallD(sD_b),
    .stallE(sE_b), .stallM(sM_b), .flushD(fD_b), .flushE(fE_b),
    .flushM(fM_b), .flushW(fW_b), .stall_cycles(cnt_dut_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Forward select of one source register from the rules in plain form.
  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (regwriteM && writeregM == src) return 2'b10;
    if (regwriteW && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  // Full expected output vector given whether memory is waiting this cycle.
  function automatic logic [15:0] m_out(input bit mw);
    logic [1:0] fa, fb, fh;
    bit fad, fbd, lw, br, se, sf;
    bit [3:0] st, fl;
    fa  = m_fwd(rsE);
    fb  = m_fwd(rtE);
    fh  = hilo_writeM ? 2'b10 : hilo_writeW ? 2'b01 : 2'b00;
    fad = (rsD != 0) && regwriteM && (writeregM == rsD);
    fbd = (rtD != 0) && regwriteM && (writeregM == rtD);
    lw  = memtoregE && ((rsD != 0 && rsD == rtE) || (rtD != 0 && rtD == rtE));
    br  = branchD && ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
                      (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
    se  = mw || stall_divE;
    sf  = se || lw || br;
    if (exceptM) begin
      st = 4'b0000;
      fl = 4'b1111;
    end else begin
      st = {sf, sf, se, mw};
      fl = {1'b0, (lw || br) && !se, stall_divE && !mw, mw};
    end
    return {fa, fb, fh, fad, fbd, st, fl};
  endfunction

  function automatic int cur_idx(input int lat, input int idx);
    if (idx < 0 && lat > 0 && memaccM) return 0;
    return idx;
  endfunction

  function automatic int next_idx(input int lat, input int ci);
    if (exceptM || ci < 0) return -1;
    if (ci + 1 > lat) return -1;
    return ci + 1;
  endfunction

  // Compare process: checks both instances against the model every cycle.
  always @(negedge clk) begin
    if (run) begin
      if (rst) begin
        idx_a = -1; idx_b = -1; cnt_a = 0; cnt_b = 0;
      end
      ci_a  = cur_idx(LAT_A, idx_a);
      ci_b  = cur_idx(LAT_B, idx_b);
      exp_a = m_out(ci_a >= 0 && ci_a < LAT_A);
      exp_b = m_out(ci_b >= 0 && ci_b < LAT_B);
      act_a = {faE_a, fbE_a, fhE_a, faD_a, fbD_a, sF_a, sD_a, sE_a, sM_a, fD_a, fE_a, fM_a, fW_a};
      act_b = {faE_b, fbE_b, fhE_b, faD_b, fbD_b, sF_b, sD_b, sE_b, sM_b, fD_b, fE_b, fM_b, fW_b};
      chk("outs_lat2", {16'h0, act_a}, {16'h0, exp_a});
      chk("outs_lat0", {16'h0, act_b}, {16'h0, exp_b});
      chk("cnt_lat2", cnt_dut_a, cnt_a[31:0]);
      chk("cnt_w2", {30'h0, cnt_dut_b}, {30'h0, cnt_b[1:0]});
      if (!rst) begin
        idx_a = next_idx(LAT_A, ci_a);
        idx_b = next_idx(LAT_B, ci_b);
        if (exp_a[7] && cnt_a < 64'hFFFF_FFFF) cnt_a++;
        if (exp_b[7] && cnt_b < 3) cnt_b++;
      end
    end
  end

  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    branchD = 0; regwriteE = 0; memtoregE = 0; stall_divE = 0; regwriteM = 0;
    memtoregM = 0; hilo_writeM = 0; memaccM = 0; exceptM = 0; regwriteW = 0; hilo_writeW = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk);
    chk("reset_cnt", cnt_dut_a, 32'd0);
    chk("reset_stallF", {31'h0, sF_a}, 32'd0);
    chk("reset_flushE", {31'h0, fE_a}, 32'd0);
    step(); rst = 1'b0;

    // forwarding priority and register 0
    rsE = 3; rtE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    @(negedge clk);
    chk("fwdaE_M", {30'h0, faE_a}, 32'h2);
    chk("fwdbE_M", {30'h0, fbE_a}, 32'h2);
    step(); regwriteM = 0;
    @(negedge clk);
    chk("fwdaE_W", {30'h0, faE_a}, 32'h1);
    step(); rsE = 0;
    @(negedge clk);
    chk("fwdaE_r0", {30'h0, faE_a}, 32'h0);

    // load-use interlock
    step(); clr(); memtoregE = 1; rtE = 5; rsD = 5;
    @(negedge clk);
    chk("lw_stallF", {31'h0, sF_a}, 32'd1);
    chk("lw_flushE", {31'h0, fE_a}, 32'd1);
    chk("lw_stallE", {31'h0, sE_a}, 32'd0);
    step(); memtoregE = 0;
    @(negedge clk);
    chk("lw_clear", {31'h0, sF_a}, 32'd0);
    chk("lw_cnt", cnt_dut_a, 32'd1);

    // back-to-back memory accesses: 1,1,0 then 1,1,0
    step(); clr(); memaccM = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mem_stallM", {31'h0, sM_a}, (i % 3 == 2) ? 32'd0 : 32'd1);
      chk("mem_flushW", {31'h0, fW_a}, (i % 3 == 2) ? 32'd0 : 32'd1);
      chk("mem_lat0", {31'h0, sM_b}, 32'd0);
      step();
    end
    memaccM = 0;
    @(negedge clk);
    chk("mem_cnt", cnt_dut_a, 32'd5);

    // exception in WAIT aborts; next access waits the full latency
    step(); memaccM = 1;
    @(negedge clk);
    step(); exceptM = 1;
    @(negedge clk);
    chk("exc_stalls", {28'h0, sF_a, sD_a, sE_a, sM_a}, 32'h0);
    chk("exc_flushes", {28'h0, fD_a, fE_a, fM_a, fW_a}, 32'hF);
    step(); exceptM = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exc_restart", {31'h0, sM_a}, (i == 2) ? 32'd0 : 32'd1);
      step();
    end
    memaccM = 0;
    @(negedge clk);
    chk("exc_cnt", cnt_dut_a, 32'd8);

    // divider stall, counter saturation on the 2-bit instance
    step(); stall_divE = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("div_stallF", {31'h0, sF_a}, 32'd1);
      chk("div_flushM", {31'h0, fM_a}, 32'd1);
      step();
    end
    stall_divE = 0;
    @(negedge clk);
    chk("div_cnt", cnt_dut_a, 32'd12);
    chk("div_sat", {30'h0, cnt_dut_b}, 32'd3);

    // hi/lo forwarding holds no state
    step(); hilo_writeM = 1;
    @(negedge clk);
    chk("hilo_M", {30'h0, fhE_a}, 32'h2);
    step(); hilo_writeM = 0;
    @(negedge clk);
    chk("hilo_none", {30'h0, fhE_a}, 32'h0);

    // reset mid-WAIT leaves no pending stall
    step(); memaccM = 1;
    @(negedge clk);
    step(); rst = 1; memaccM = 0;
    @(negedge clk);
    chk("rst_abort", {31'h0, sM_a}, 32'd0);
    step(); rst = 0;
    @(negedge clk);
    chk("rst_idle", {31'h0, sM_a}, 32'd0);
    chk("rst_cnt", cnt_dut_a, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      rsD = 5'($urandom_range(0, 3));  rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3));  rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      branchD     = ($urandom_range(0, 3) == 0);
      regwriteE   = $urandom_range(0, 1) == 1;
      memtoregE   = ($urandom_range(0, 3) == 0);
      stall_divE  = ($urandom_range(0, 7) == 0);
      regwriteM   = $urandom_range(0, 1) == 1;
      memtoregM   = ($urandom_range(0, 3) == 0);
      hilo_writeM = ($urandom_range(0, 2) == 0);
      memaccM     = ($urandom_range(0, 2) == 0);
      exceptM     = ($urandom_range(0, 29) == 0);
      regwriteW   = $urandom_range(0, 1) == 1;
      hilo_writeW = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
